// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared types and constants for the MIPS program loader
package mips_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LOAD  = 3'd1,
    CSUM  = 3'd2,
    START = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/mips_prog_loader_if.sv
// rtl/mips_prog_loader_if.sv - byte stream handshake between a byte source and the loader
interface mips_prog_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/mips_byte_packer.sv
// rtl/mips_byte_packer.sv - assembles accepted bytes into big-endian 32-bit words
module mips_byte_packer
  import mips_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              take_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic [1:0]        cnt_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]        cnt_q;
  logic [WORD_W-9:0] shift_q;

  // Earlier bytes sit in the shift register; the word is complete as the last byte is taken.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = take_i && !clr_i && (cnt_q == LAST_BYTE);
  assign cnt_o        = cnt_q;

  // Byte counter and shift register; the first byte of a word ends up in the top byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else if (clr_i) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else if (take_i) begin
      shift_q <= {shift_q[WORD_W-17:0], byte_i};
      cnt_q   <= (cnt_q == LAST_BYTE) ? 2'd0 : cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - boot loader writing a byte-streamed program into MIPS memory (option: LOADER_CSUM_EN)
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
)
(
  input  logic              clk1,
  input  logic              rst_n,
  mips_prog_loader_if.slave in_if,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE_N = (ADDR_W+1)'(1);

  loader_state_e     state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              cpu_start_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   n_q;
`ifdef LOADER_CSUM_EN
  logic [31:0]       csum_q;
`endif

  logic              fire;
  logic              pk_clr;
  logic [WORD_W-1:0] pk_word;
  logic              pk_valid;
  logic [1:0]        pk_cnt;
  logic [ADDR_W:0]   hdr_len;
  logic              hdr_ok;
  logic [ADDR_W:0]   words_inc;

  assign fire      = in_if.in_valid && in_ready_q;
  assign pk_clr    = (state_q == START);
  assign hdr_len   = pk_word[ADDR_W:0];
  assign hdr_ok    = (pk_word[WORD_W-1:ADDR_W+1] == '0) && (hdr_len != '0) && (hdr_len <= MAX_N);
  assign words_inc = words_q + ONE_N;

  mips_byte_packer u_packer (
    .clk_i        (clk1),
    .rst_ni       (rst_n),
    .clr_i        (pk_clr),
    .take_i       (fire),
    .byte_i       (in_if.in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_valid),
    .cnt_o        (pk_cnt)
  );

  // Loader FSM; every output is a register updated together with the state.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      n_q         <= '0;
`ifdef LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      mem_we_q    <= 1'b0;
      cpu_start_q <= 1'b0;
      case (state_q)
        HDR: begin
          in_ready_q <= 1'b1;
          cpu_hold_q <= 1'b1;
          if (fire) begin
            busy_q <= 1'b1;
            if (pk_cnt == 2'd0) done_q <= 1'b0;
          end
          if (pk_valid) begin
            if (hdr_ok) begin
              n_q     <= hdr_len;
              words_q <= '0;
`ifdef LOADER_CSUM_EN
              csum_q  <= '0;
`endif
              state_q <= LOAD;
            end else begin
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= ERR;
            end
          end
        end
        LOAD: begin
          if (pk_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= words_q[ADDR_W-1:0];
            mem_wdata_q <= pk_word;
            words_q     <= words_inc;
`ifdef LOADER_CSUM_EN
            csum_q      <= csum_q ^ pk_word;
            if (words_inc == n_q) state_q <= CSUM;
`else
            if (words_inc == n_q) begin
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              cpu_hold_q  <= 1'b0;
              cpu_start_q <= 1'b1;
              state_q     <= START;
            end
`endif
          end
        end
`ifdef LOADER_CSUM_EN
        CSUM: begin
          if (pk_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (pk_word == csum_q) begin
              cpu_hold_q  <= 1'b0;
              cpu_start_q <= 1'b1;
              state_q     <= START;
            end else begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end
          end
        end
`endif
        START: begin
          state_q <= RUN;
        end
        RUN: begin
          if (cpu_halted) begin
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= HDR;
          end
        end
        ERR: begin
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
          busy_q     <= 1'b0;
          err_q      <= 1'b1;
        end
        default: begin
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
          busy_q     <= 1'b0;
          err_q      <= 1'b1;
          state_q    <= ERR;
        end
      endcase
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign cpu_start      = cpu_start_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - scoreboard bench for mips_prog_loader (option: LOADER_CSUM_EN)
module tb_mips_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_halted = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  mips_prog_loader_if in_if();

  mips_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .in_if        (in_if),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .cpu_start    (cpu_start),
    .cpu_halted   (cpu_halted),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  checks = 0;
  int  failures = 0;
  int  start_cnt = 0;
  int  acc_bytes = 0;

  localparam bit CSUM_ON =
`ifdef LOADER_CSUM_EN
    1'b1;
`else
    1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the expected write on every mem_we and tallies handshakes and start pulses.
  always @(negedge clk1) begin
    if (rst_n) begin
      if (in_if.in_valid && in_if.in_ready) acc_bytes++;
      if (cpu_start) begin
        start_cnt++;
        chk("start_with_hold_low", {31'd0, cpu_hold}, 32'd0);
      end
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%h data=%h required no write", mem_addr, mem_wdata);
        end else begin
          exp_e = exp_q.pop_front();
          chk("wr_addr", {22'd0, mem_addr}, {22'd0, exp_e.addr});
          chk("wr_data", mem_wdata, exp_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    if (gap > 0) begin
      in_if.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk1); #1; end
    end
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk1);
      acc = in_if.in_ready;
      @(posedge clk1);
      #1;
    end
    in_if.in_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], $urandom_range(0, maxgap));
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", {31'd0, in_if.in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words_loaded", {21'd0, words_loaded}, 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk1);
    #3 rst_n = 1'b1;
    @(posedge clk1);
    #1;
  endtask

  // Sends header, payload and (when enabled) a checksum; the model expects word i at address i.
  task automatic load_program(input logic [31:0] words[$], input int maxgap,
                              input logic [31:0] csum_flip, input bit expect_start);
    int          s0 = start_cnt;
    int          b0 = acc_bytes;
    logic [31:0] x = 32'd0;
    int          n = words.size();
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: 10'(i), data: words[i]});
    send_word(32'(n), maxgap);
    chk("hdr_busy", {31'd0, busy}, 32'd1);
    chk("hdr_done_cleared", {31'd0, done}, 32'd0);
    foreach (words[i]) begin
      send_word(words[i], maxgap);
      x = x ^ words[i];
    end
    if (CSUM_ON) send_word(x ^ csum_flip, maxgap);
    for (int t = 0; t < 20 && start_cnt == s0; t++) @(negedge clk1);
    @(posedge clk1);
    #1;
    chk("start_pulses", 32'(start_cnt - s0), expect_start ? 32'd1 : 32'd0);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("words_loaded", {21'd0, words_loaded}, 32'(n));
    chk("bytes_accepted", 32'(acc_bytes - b0), 32'(4 * (n + 1 + (CSUM_ON ? 1 : 0))));
    if (expect_start) begin
      chk("run_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("run_in_ready", {31'd0, in_if.in_ready}, 32'd0);
      chk("run_start_one_cycle", {31'd0, cpu_start}, 32'd0);
    end else begin
      chk("csum_err", {31'd0, err}, 32'd1);
      chk("csum_err_hold", {31'd0, cpu_hold}, 32'd1);
      chk("csum_err_ready", {31'd0, in_if.in_ready}, 32'd0);
    end
  endtask

  task automatic halt_cpu();
    int b0 = acc_bytes;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'hA5;
    repeat (3) begin @(posedge clk1); #1; end
    in_if.in_valid = 1'b0;
    chk("run_bytes_refused", 32'(acc_bytes - b0), 32'd0);
    cpu_halted = 1'b1;
    @(posedge clk1);
    #1 cpu_halted = 1'b0;
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("halt_in_ready", {31'd0, in_if.in_ready}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic hdr_err(input logic [31:0] hdr);
    send_word(hdr, 2);
    chk("hdr_err_flag", {31'd0, err}, 32'd1);
    chk("hdr_err_ready", {31'd0, in_if.in_ready}, 32'd0);
    chk("hdr_err_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) begin @(posedge clk1); #1; end
    chk("hdr_err_sticky", {31'd0, err}, 32'd1);
    apply_reset();
  endtask

  logic [31:0] sum_prog[$];
  logic [31:0] prog[$];

  initial begin
    sum_prog = '{32'h0ce77800, 32'h2801000f, 32'h28020014, 32'h28030019, 32'h0ce77800,
                 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    repeat (3) @(posedge clk1);
    #1 check_reset_outputs();
    @(posedge clk1);
    #3 rst_n = 1'b1;
    @(posedge clk1);
    #1 chk("hdr_in_ready", {31'd0, in_if.in_ready}, 32'd1);

    load_program(sum_prog, 0, 32'd0, 1'b1);
    halt_cpu();

    cpu_halted = 1'b1;
    @(posedge clk1);
    #1 cpu_halted = 1'b0;
    chk("halted_ignored_hold", {31'd0, cpu_hold}, 32'd1);
    chk("halted_ignored_ready", {31'd0, in_if.in_ready}, 32'd1);

    load_program(sum_prog, 7, 32'd0, 1'b1);
    halt_cpu();

    for (int p = 0; p < 4; p++) begin
      prog.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) prog.push_back($urandom);
      load_program(prog, $urandom_range(0, 7), 32'd0, 1'b1);
      halt_cpu();
    end

    hdr_err(32'h00000000);
    hdr_err(32'h00000401);
    hdr_err(32'h00010003);

    exp_q.push_back('{addr: 10'd0, data: 32'hdeadbeef});
    exp_q.push_back('{addr: 10'd1, data: 32'h01234567});
    send_word(32'h00000004, 1);
    send_word(32'hdeadbeef, 1);
    send_word(32'h01234567, 1);
    repeat (2) begin @(posedge clk1); #1; end
    chk("abort_writes_done", 32'(exp_q.size()), 32'd0);
    chk("abort_words_loaded", {21'd0, words_loaded}, 32'd2);
    apply_reset();
    repeat (4) begin @(posedge clk1); #1; end
    load_program(sum_prog, 3, 32'd0, 1'b1);
    halt_cpu();

    prog.delete();
    for (int i = 0; i < 1024; i++) prog.push_back($urandom);
    load_program(prog, 0, 32'd0, 1'b1);
    halt_cpu();

`ifdef LOADER_CSUM_EN
    prog = '{32'h11111111, 32'h22222222};
    load_program(prog, 2, 32'd0, 1'b1);
    halt_cpu();
    load_program(prog, 2, 32'h00000001, 1'b0);
    apply_reset();
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the pipelined MIPS32 core.
- Receives a byte stream (e.g. from a UART RX) and assembles it into big-endian 32-bit instruction words.
- Writes the words into the core's instruction/data memory from address 0.
- Holds the core halted during the load, then releases it with a one-cycle start pulse; regains control when the core executes HLT.

Parameters:
- ADDR_W, 10, memory word-address width.
- MAX_WORDS, 1024, largest accepted program length in words; must be <= 2**ADDR_W.

Ports:
- clk1  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  forces the core halted and PC held at 0 while high.
- cpu_start  out  1  one-cycle pulse; the core clears HALTED/BRANCH_TAKEN and sets PC=0.
- cpu_halted  in  1  core has retired HLT.
- busy  out  1  high in HDR (after its first byte), LOAD and CSUM.
- done  out  1  sticky; set when cpu_halted is seen in RUN, cleared on the first byte of the next header.
- err  out  1  sticky error flag.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset values (asynchronous, rst_n low): state=HDR; cpu_hold=1; all other outputs and counters 0.
- Outputs:
  - in_ready=1 only in HDR, LOAD and CSUM.
  - All outputs are registered.
- Byte assembly:
  - A 2-bit byte counter increments on each transfer; the first byte goes to [31:24], the fourth to [7:0].
  - The counter wraps to 0 after the fourth byte, which completes the word.
  - in_valid gaps of any length are tolerated; no timeout.
- States:
  - HDR: the completed word is the length N = word[ADDR_W:0], with the upper bits required to be zero.
    - N==0, N>MAX_WORDS, or nonzero upper bits -> ERR.
    - Otherwise latch N, clear words_loaded -> LOAD.
  - LOAD: each completed word registers mem_we=1, mem_addr=words_loaded[ADDR_W-1:0] and mem_wdata=word in the cycle after the fourth byte is accepted. words_loaded increments in that same cycle.
    - When words_loaded reaches N -> CSUM if enabled, else START.
    - in_ready stays high during the write cycle; no back-pressure bubble.
  - START: cpu_hold=0 and cpu_start=1 for exactly one cycle -> RUN.
  - RUN: in_ready=0 and cpu_hold=0.
    - On cpu_halted=1 set done, cpu_hold=1 -> HDR.
    - Bytes offered in RUN are not accepted.
  - ERR: err=1, cpu_hold=1, in_ready=0. Exit only via rst_n.
- Boundaries:
  - N==MAX_WORDS is valid; the final address is MAX_WORDS-1.
  - cpu_halted is ignored outside RUN.
  - Reset mid-load aborts immediately with no further mem_we. Memory contents already written are left as-is.
  - mem_we never asserts in HDR, CSUM, START, RUN or ERR.

Optional Feature:
- Macro LOADER_CSUM_EN.
- Defined:
  - A running 32-bit XOR of all payload words (the header is excluded) is kept.
  - After word N the state goes to CSUM, which accepts one more 4-byte word.
  - If that word equals the XOR -> START; otherwise -> ERR and the core is never released.
- Undefined: no CSUM state and no accumulator; LOAD -> START directly.

Decomposition:
- Package mips_loader_pkg:
  - state enum (HDR, LOAD, CSUM, START, RUN, ERR);
  - WORD_W=32;
  - BYTES_PER_WORD=4.
- One sub-module, mips_byte_packer: byte counter, shift register, word_valid pulse, synchronous clear. The FSM, address counter and checksum live in the top level.

Test Plan:
- Sum program: header 0x0000000A, then 0x0ce77800, 0x2801000f, 0x28020014, 0x28030019, 0x0ce77800, 0x0ce77800, 0x00222000, 0x0ce77800, 0x00832800, 0xfc000000.
  - Expect 10 mem_we pulses at addresses 0..9 with exactly these words, and words_loaded=10.
  - Expect a single cpu_start pulse with cpu_hold low afterwards.
  - Drive cpu_halted=1: expect done=1, cpu_hold=1, state HDR.
- Random in_valid gaps of 0-7 cycles on the same stream -> identical writes and order, one write per 4 accepted bytes.
- Header 0x00000000 -> err=1, in_ready=0, no mem_we, cpu_hold stays 1. Header 0x00000401 with MAX_WORDS=1024 -> same result.
- Header 0x00000004, assert rst_n low after 2 words -> all outputs return to reset values immediately, no further writes. A full reload after reset succeeds.
- LOADER_CSUM_EN, header 2, words 0x11111111, 0x22222222:
  - checksum 0x33333333 -> START;
  - checksum 0x33333332 -> err=1, no cpu_start.
